stream_demux: RTL

//   Routes a single valid/ready input stream to one of N output channels,

---
 rtl/stream_demux_if.sv | 25 ++
 rtl/stream_demux.sv | 105 ++++++++++
 2 files changed

// File: rtl/stream_demux_if.sv
// Stream bundle for stream_demux: one valid/ready input stream and
// N one-hot-addressed output channels that share a single payload bus.
interface stream_demux_if #(
    parameter int N = 4,
    parameter int W = 32
);
    logic         i_in_vld;
    logic [N-1:0] i_in_sel;
    logic [W-1:0] i_in_data;
    logic         o_in_rdy;
    logic [N-1:0] o_out_vld;
    logic [W-1:0] o_out_data;
    logic [N-1:0] i_out_rdy;
    logic         o_sel_err;

    modport master (
        output i_in_vld, i_in_sel, i_in_data, i_out_rdy,
        input  o_in_rdy, o_out_vld, o_out_data, o_sel_err
    );

    modport slave (
        input  i_in_vld, i_in_sel, i_in_data, i_out_rdy,
        output o_in_rdy, o_out_vld, o_out_data, o_sel_err
    );
endinterface

// File: rtl/stream_demux.sv
// One-hot demultiplexer with a two-entry (head + skid) buffer and a
// registered input ready. Beats carrying an illegal select are dropped and flagged.
module stream_demux #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           arst,
    stream_demux_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] head_sel_q, head_sel_d;
    logic [W-1:0] head_data_q, head_data_d;
    logic [N-1:0] skid_sel_q, skid_sel_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         rdy_q, rdy_d;
    logic         err_q, err_d;

    logic legal;
    logic accept;
    logic push;
    logic pop;

    // A select is legal only when exactly one bit is set.
    assign legal  = (bus.i_in_sel != '0) &&
                    ((bus.i_in_sel & (bus.i_in_sel - N'(1))) == '0);
    assign accept = bus.i_in_vld & rdy_q;
    assign push   = accept & legal;
    assign pop    = |(bus.o_out_vld & bus.i_out_rdy);

    assign bus.o_out_vld  = (state_q == EMPTY) ? '0 : head_sel_q;
    assign bus.o_out_data = head_data_q;
    assign bus.o_in_rdy   = rdy_q;
    assign bus.o_sel_err  = err_q;

    always_comb begin
        state_d     = state_q;
        head_sel_d  = head_sel_q;
        head_data_d = head_data_q;
        skid_sel_d  = skid_sel_q;
        skid_data_d = skid_data_q;
        err_d       = accept & ~legal;

        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d     = ONE;
                    head_sel_d  = bus.i_in_sel;
                    head_data_d = bus.i_in_data;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_sel_d  = bus.i_in_sel;
                    head_data_d = bus.i_in_data;
                end else if (push) begin
                    state_d     = TWO;
                    skid_sel_d  = bus.i_in_sel;
                    skid_data_d = bus.i_in_data;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // Ready is low here, so only a pop can change occupancy.
                if (pop) begin
                    state_d     = ONE;
                    head_sel_d  = skid_sel_q;
                    head_data_d = skid_data_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        rdy_d = (state_d != TWO);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= EMPTY;
            head_sel_q  <= '0;
            head_data_q <= '0;
            skid_sel_q  <= '0;
            skid_data_q <= '0;
            rdy_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_sel_q  <= head_sel_d;
            head_data_q <= head_data_d;
            skid_sel_q  <= skid_sel_d;
            skid_data_q <= skid_data_d;
            rdy_q       <= rdy_d;
            err_q       <= err_d;
        end
    end
endmodule
